// File: rtl/sort_frame_feeder_pkg.sv
// Shared widths and FSM state encoding for the sort frame feeder and its packer.
`timescale 1ns/1ps
package sort_frame_feeder_pkg;

    localparam int ARRAYWIDTH          = 8;
    localparam int OUTPUT_BUF_DATASIZE = 16;

    typedef enum logic [1:0] {
        SORTFEED_FILL   = 2'd0,
        SORTFEED_LOAD   = 2'd1,
        SORTFEED_WAIT   = 2'd2,
        SORTFEED_RESULT = 2'd3
    } feed_state_e;

endpackage

// File: rtl/sort_frame_feeder_if.sv
// Element input, sorter pair and result port of the feeder, bundled as one interface.
`timescale 1ns/1ps
interface sort_frame_feeder_if #(
    parameter int ARRAY_W = sort_frame_feeder_pkg::ARRAYWIDTH,
    parameter int DATA_W  = sort_frame_feeder_pkg::OUTPUT_BUF_DATASIZE
) ();

    // Both ports are valid/ready: a beat transfers on a rising edge where valid and
    // ready are both high; data is ignored otherwise and ready may depend only on state.
    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_W-1:0]         in_data;
    logic                      in_last;
    logic                      sort_en;
    logic [ARRAY_W*DATA_W-1:0] sort_in;
    logic [DATA_W-1:0]         sort_max;
    logic                      res_valid;
    logic                      res_ready;
    logic [DATA_W-1:0]         res_data;
    logic                      busy;

    modport master (
        output in_valid, in_data, in_last, res_ready, sort_max,
        input  in_ready, sort_en, sort_in, res_valid, res_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_last, res_ready, sort_max,
        output in_ready, sort_en, sort_in, res_valid, res_data, busy
    );

endinterface

// File: rtl/sort_frame_packer.sv
// Slot register array that assembles serial elements into one packed sorter frame.
`timescale 1ns/1ps
module sort_frame_packer #(
    parameter int ARRAY_W = 8,
    parameter int DATA_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic                      wr_last,
    input  logic                      clr,
    output logic                      at_last_slot,
    output logic [ARRAY_W*DATA_W-1:0] frame
);

    localparam int IDX_W = (ARRAY_W > 1) ? $clog2(ARRAY_W) : 1;

    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [ARRAY_W-1:0][DATA_W-1:0]  slot_q, slot_d;

    assign at_last_slot = (idx_q == IDX_W'(ARRAY_W - 1));
    assign frame        = slot_q;

    // A short frame zeroes every slot above the final element, which is neutral for max.
    always_comb begin
        idx_d  = idx_q;
        slot_d = slot_q;
        if (clr) begin
            idx_d  = '0;
            slot_d = '0;
        end else if (wr_en) begin
            idx_d = idx_q + IDX_W'(1);
            for (int k = 0; k < ARRAY_W; k++) begin
                if (k == int'(idx_q)) begin
                    slot_d[k] = wr_data;
                end else if (wr_last && (k > int'(idx_q))) begin
                    slot_d[k] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= '0;
            slot_q <= '0;
        end else begin
            idx_q  <= idx_d;
            slot_q <= slot_d;
        end
    end

endmodule

// File: rtl/sort_frame_feeder.sv
// Feeds packed frames to the odd-even sorter, holds them for its latency and returns the max.
`timescale 1ns/1ps
module sort_frame_feeder import sort_frame_feeder_pkg::*; #(
    parameter int ARRAY_W  = ARRAYWIDTH,
    parameter int DATA_W   = OUTPUT_BUF_DATASIZE,
    parameter int SORT_LAT = ARRAY_W
) (
    input  logic                clk,
    input  logic                rst,
    sort_frame_feeder_if.slave  bus,
    output feed_state_e         dbg_state
);

    feed_state_e        state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               res_valid_q, res_valid_d;
    logic [DATA_W-1:0]  res_data_q, res_data_d;
    logic               pack_wr, pack_clr, at_last_slot;

    sort_frame_packer #(
        .ARRAY_W (ARRAY_W),
        .DATA_W  (DATA_W)
    ) u_packer (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (pack_wr),
        .wr_data      (bus.in_data),
        .wr_last      (bus.in_last),
        .clr          (pack_clr),
        .at_last_slot (at_last_slot),
        .frame        (bus.sort_in)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SORTFEED_FILL;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        pack_wr     = 1'b0;
        pack_clr    = 1'b0;
        case (state_q)
            SORTFEED_FILL: begin
                if (bus.in_valid) begin
                    pack_wr = 1'b1;
                    if (at_last_slot || bus.in_last) state_d = SORTFEED_LOAD;
                end
            end
            SORTFEED_LOAD: begin
                state_d = SORTFEED_WAIT;
                cnt_d   = 8'(SORT_LAT - 1);
            end
            SORTFEED_WAIT: begin
                // The sorter's max is sampled on the same edge that leaves WAIT.
                if (cnt_q == 8'd0) begin
                    res_data_d  = bus.sort_max;
                    res_valid_d = 1'b1;
                    state_d     = SORTFEED_RESULT;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            SORTFEED_RESULT: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    pack_clr    = 1'b1;
                    state_d     = SORTFEED_FILL;
                end
            end
            default: state_d = SORTFEED_FILL;
        endcase
    end

    always_comb begin
        bus.in_ready = (state_q == SORTFEED_FILL);
        bus.sort_en  = (state_q == SORTFEED_LOAD) || (state_q == SORTFEED_WAIT);
        bus.busy     = (state_q != SORTFEED_FILL);
    end

    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_sort_frame_feeder.sv
// Bench for sort_frame_feeder: frame table plus random frames against a behavioural sorter.
`timescale 1ns/1ps
module tb_sort_frame_feeder;
    import sort_frame_feeder_pkg::*;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int SL = 8;
    localparam int FW = AW * DW;

    typedef struct {
        int            n;
        logic [DW-1:0] d [AW];
        logic [FW-1:0] exp_in;
        logic [DW-1:0] exp_max;
        int            gap;
        int            hold;
        bit            last8;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    feed_state_e dbg_state;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    vec_t        vecs [$];
    logic [DW-1:0] exp_q [$];

    sort_frame_feeder_if #(.ARRAY_W(AW), .DATA_W(DW)) bus ();

    sort_frame_feeder #(.ARRAY_W(AW), .DATA_W(DW), .SORT_LAT(SL)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // behavioural sorter: max of the presented frame while enabled
    function automatic logic [DW-1:0] frame_max(input logic [FW-1:0] f);
        logic [DW-1:0] m = '0;
        for (int k = 0; k < AW; k++) if (f[k*DW +: DW] > m) m = f[k*DW +: DW];
        return m;
    endfunction

    assign bus.sort_max = bus.sort_en ? frame_max(bus.sort_in) : '0;

    // reference model
    function automatic logic [FW-1:0] model_pack(input vec_t v);
        logic [FW-1:0] p = '0;
        for (int k = 0; k < v.n; k++) p[k*DW +: DW] = v.d[k];
        return p;
    endfunction

    function automatic logic [DW-1:0] model_max(input vec_t v);
        logic [DW-1:0] m = '0;
        for (int k = 0; k < v.n; k++) if (v.d[k] > m) m = v.d[k];
        return m;
    endfunction

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // driver + monitor for table entries lo..hi streamed in order
    task automatic run_vecs(input int lo, input int hi);
        int f_drv = lo, k_drv = 0, f_pop = lo;
        int sen_cnt = 0, rv_cnt = 0, budget = 0, gctr = 0;
        int last_acc = 0, pop_edge = 0;
        logic prev_sen = 1'b0, prev_rv = 1'b0;
        logic [DW-1:0] held = '0;
        logic [DW-1:0] exp_max;
        for (int i = lo; i <= hi; i++) exp_q.push_back(vecs[i].exp_max);
        while (f_pop <= hi && budget < 2000) begin
            @(negedge clk);
            budget++;
            if (bus.sort_en) begin
                if (!prev_sen) check("sort_in", bus.sort_in, vecs[f_pop].exp_in);
                sen_cnt++;
            end else if (prev_sen) begin
                check("sort_en_len", FW'(sen_cnt), FW'(SL + 1));
                sen_cnt = 0;
            end
            if (bus.res_valid) begin
                if (!prev_rv) begin
                    check("res_latency", FW'(cyc), FW'(last_acc + SL + 1));
                    held   = bus.res_data;
                    rv_cnt = 0;
                end else begin
                    check("res_data_stable", FW'(bus.res_data), FW'(held));
                end
                check("in_ready_in_result", FW'(bus.in_ready), FW'(0));
                bus.res_ready = (rv_cnt >= vecs[f_pop].hold);
                rv_cnt++;
                if (bus.res_ready) begin
                    exp_max = exp_q.pop_front();
                    check("res_data", FW'(bus.res_data), FW'(exp_max));
                    pop_edge = cyc + 1;
                    f_pop++;
                end
            end else begin
                bus.res_ready = 1'($urandom_range(0, 1));
            end
            prev_sen = bus.sort_en;
            prev_rv  = bus.res_valid;
            if (f_drv <= hi && ((vecs[lo].gap == 0) || (gctr % 3 == 0))) begin
                bus.in_valid = 1'b1;
                bus.in_data  = vecs[f_drv].d[k_drv];
                bus.in_last  = (k_drv == vecs[f_drv].n - 1) &&
                               (vecs[f_drv].n < AW || vecs[f_drv].last8);
            end else begin
                bus.in_valid = 1'b0;
                bus.in_data  = DW'($urandom);
                bus.in_last  = 1'($urandom_range(0, 1));
            end
            gctr++;
            if (bus.in_valid && bus.in_ready) begin
                if (k_drv == 0 && f_drv > lo && vecs[lo].gap == 0)
                    check("b2b_first_accept", FW'(cyc + 1), FW'(pop_edge + 1));
                if (k_drv == vecs[f_drv].n - 1) begin
                    last_acc = cyc + 1;
                    k_drv    = 0;
                    f_drv++;
                end else begin
                    k_drv++;
                end
            end
        end
        if (budget >= 2000) begin
            n_errors++;
            $display("FAIL timeout: run %0d..%0d popped %0d frames", lo, hi, f_pop - lo);
            exp_q.delete();
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.res_ready = 1'b0;
    endtask

    task automatic add_vec(input int n, input logic [DW-1:0] d [AW], input logic [FW-1:0] exp_in,
                           input logic [DW-1:0] exp_max, input int gap, input int hold);
        vec_t v;
        v.n = n; v.d = d; v.exp_in = exp_in; v.exp_max = exp_max;
        v.gap = gap; v.hold = hold; v.last8 = 1'b0;
        vecs.push_back(v);
    endtask

    task automatic add_random(input int gap);
        vec_t v;
        v.n = $urandom_range(1, AW);
        for (int k = 0; k < AW; k++) v.d[k] = DW'($urandom);
        v.exp_in  = model_pack(v);
        v.exp_max = model_max(v);
        v.gap     = gap;
        v.hold    = $urandom_range(0, 3);
        v.last8   = 1'($urandom_range(0, 1));
        vecs.push_back(v);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_state"},     FW'(dbg_state),     FW'(SORTFEED_FILL));
        check({tag, "_in_ready"},  FW'(bus.in_ready),  FW'(1));
        check({tag, "_busy"},      FW'(bus.busy),      FW'(0));
        check({tag, "_sort_en"},   FW'(bus.sort_en),   FW'(0));
        check({tag, "_res_valid"}, FW'(bus.res_valid), FW'(0));
        check({tag, "_sort_in"},   bus.sort_in,        FW'(0));
    endtask

    initial begin
        logic [DW-1:0] f_main [AW] = '{16'd3, 16'd7, 16'd1, 16'd8, 16'd2, 16'd6, 16'd5, 16'd4};
        logic [DW-1:0] f_short[AW] = '{16'h0010, 16'h00FF, 16'h0002, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        logic [DW-1:0] f_ffff [AW] = '{16'd1, 16'd2, 16'hFFFF, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
        logic [DW-1:0] f_nine [AW] = '{default: 16'd9};
        int accepts, waited;

        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.res_ready = 1'b0;

        add_vec(8, f_main,  128'h0004_0005_0006_0002_0008_0001_0007_0003, 16'd8,    0, 0); // 0 full
        add_vec(3, f_short, 128'h0000_0000_0000_0000_0000_0002_00FF_0010, 16'h00FF, 0, 0); // 1 short
        add_vec(8, f_main,  128'h0004_0005_0006_0002_0008_0001_0007_0003, 16'd8,    1, 0); // 2 gaps
        add_vec(8, f_main,  128'h0004_0005_0006_0002_0008_0001_0007_0003, 16'd8,    0, 5); // 3 backpressure
        add_vec(3, f_short, 128'h0000_0000_0000_0000_0000_0002_00FF_0010, 16'h00FF, 0, 0); // 4 after pop
        add_vec(8, f_main,  128'h0004_0005_0006_0002_0008_0001_0007_0003, 16'd8,    0, 0); // 5 b2b
        add_vec(8, f_ffff,  128'h0008_0007_0006_0005_0004_FFFF_0002_0001, 16'hFFFF, 0, 0); // 6 b2b
        add_vec(8, f_nine,  128'h0009_0009_0009_0009_0009_0009_0009_0009, 16'd9,    0, 0); // 7 nines
        vecs[0].last8 = 1'b1;

        repeat (2) @(negedge clk);
        check_idle("reset");
        check("reset_res_data", FW'(bus.res_data), FW'(0));
        rst = 1'b0;

        run_vecs(0, 0);
        run_vecs(1, 1);
        run_vecs(2, 2);
        run_vecs(3, 4);
        run_vecs(5, 6);

        // reset while the sorter wait counter reads 3
        accepts = 0; waited = 0;
        while (accepts < AW && waited < 100) begin
            @(negedge clk); waited++;
            bus.in_valid = 1'b1; bus.in_data = DW'(accepts + 1); bus.in_last = 1'b0;
            if (bus.in_ready) accepts++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("rst_test_load", FW'(dbg_state), FW'(SORTFEED_LOAD));
        repeat (5) @(negedge clk);
        check("rst_test_wait", FW'(dbg_state), FW'(SORTFEED_WAIT));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("mid_wait_reset");
        run_vecs(7, 7);

        for (int r = 0; r < 4; r++) begin
            int base = vecs.size();
            int g = $urandom_range(0, 1);
            for (int j = 0; j < 3; j++) add_random(g);
            run_vecs(base, base + 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
